// File: rtl/yubex_edge_event_counter.sv
// Edge event counter: saturating rise/fall counts shown as two hex digits
// sequenced on one 7-segment display (high digit, low digit, blank).
module yubex_edge_event_counter #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DISP_PERIOD  = 6250,
  parameter int unsigned BLANK_PERIOD = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rise_evt,
  input  logic       fall_evt,
  input  logic       sel,
  input  logic       clr,
  output logic [6:0] seg,
  output logic       dp,
  output logic       ovf
);

  localparam logic [1:0] ST_BLANK   = 2'd0;
  localparam logic [1:0] ST_SHOW_HI = 2'd1;
  localparam logic [1:0] ST_SHOW_LO = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned MAX_P = (DISP_PERIOD > BLANK_PERIOD) ? DISP_PERIOD : BLANK_PERIOD;
  localparam int unsigned TMR_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam logic [TMR_W-1:0] DISP_LAST  = TMR_W'(DISP_PERIOD - 1);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_PERIOD - 1);

  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             ovf_rise_q, ovf_rise_d;
  logic             ovf_fall_q, ovf_fall_d;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] period_last;
  logic [7:0]       snap_q, snap_d, snap_src;
  logic [6:0]       seg_d;
  logic             dp_d, ovf_d;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Saturating counters; an event while already at max sets the sticky flag.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    ovf_rise_d = ovf_rise_q;
    ovf_fall_d = ovf_fall_q;
    if (rise_evt) begin
      if (rise_cnt_q == CNT_MAX) ovf_rise_d = 1'b1;
      else                       rise_cnt_d = rise_cnt_q + CNT_W'(1);
    end
    if (fall_evt) begin
      if (fall_cnt_q == CNT_MAX) ovf_fall_d = 1'b1;
      else                       fall_cnt_d = fall_cnt_q + CNT_W'(1);
    end
  end

  // Snapshot source uses the post-event count so a same-cycle edge is included.
  always_comb begin
    snap_src = sel ? 8'(fall_cnt_d) : 8'(rise_cnt_d);
  end

  // Display sequencer: per-state timer, wraps and advances on its last cycle.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TMR_W'(1);
    snap_d      = snap_q;
    period_last = (state_q == ST_BLANK) ? BLANK_LAST : DISP_LAST;
    if (timer_q == period_last) begin
      timer_d = '0;
      case (state_q)
        ST_BLANK: begin
          state_d = ST_SHOW_HI;
          snap_d  = snap_src;
        end
        ST_SHOW_HI: state_d = ST_SHOW_LO;
        default:    state_d = ST_BLANK;
      endcase
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    seg_d = 7'h00;
    dp_d  = 1'b0;
    ovf_d = ovf_rise_q | ovf_fall_q;
    case (state_q)
      ST_SHOW_HI: begin
        seg_d = hex7(snap_q[7:4]);
        dp_d  = 1'b1;
      end
      ST_SHOW_LO: seg_d = hex7(snap_q[3:0]);
      default:    seg_d = (ovf_rise_q | ovf_fall_q) ? 7'h40 : 7'h00;
    endcase
  end

  // Counter and flag state; clr discards any same-cycle events.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      ovf_rise_q <= 1'b0;
      ovf_fall_q <= 1'b0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      ovf_rise_q <= ovf_rise_d;
      ovf_fall_q <= ovf_fall_d;
    end
  end

  // Sequencer state; clr restarts the display sequence at blank.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= ST_BLANK;
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      snap_q  <= snap_d;
    end
  end

  // Output register, one cycle behind the sequencer state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 7'h00;
      dp  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_yubex_edge_event_counter.sv
// Self-checking bench for yubex_edge_event_counter with short display periods.
module tb_yubex_edge_event_counter;

  localparam int unsigned DPER = 4;
  localparam int unsigned BPER = 2;

  logic       clk = 1'b0;
  logic       rst_n, rise_evt, fall_evt, sel, clr;
  logic [6:0] seg;
  logic       dp, ovf;

  always #5 clk = ~clk;

  yubex_edge_event_counter #(
    .CNT_W       (8),
    .DISP_PERIOD (DPER),
    .BLANK_PERIOD(BPER)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rise_evt(rise_evt),
    .fall_evt(fall_evt),
    .sel     (sel),
    .clr     (clr),
    .seg     (seg),
    .dp      (dp),
    .ovf     (ovf)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state (0 = blank, 1 = high digit, 2 = low digit)
  int m_rise, m_fall, m_state, m_timer, m_snap;
  bit m_or, m_of, m_valid;

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
      4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
      8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected output k cycles after a restart edge (reset release or clr), zero count.
  function automatic void restart_seq(input int k, output logic [6:0] s, output logic d);
    if (k < 2)       begin s = 7'h00; d = 1'b0; end
    else if (k < 6)  begin s = 7'h3F; d = 1'b1; end
    else if (k < 10) begin s = 7'h3F; d = 1'b0; end
    else             begin s = 7'h00; d = 1'b0; end
  endfunction

  task automatic model_zero();
    m_rise = 0; m_fall = 0; m_or = 0; m_of = 0;
    m_state = 0; m_timer = 0; m_snap = 0;
  endtask

  // One clock: advance the model, push its expectation, then compare the DUT.
  task automatic tick();
    exp_t e;
    int   per;
    @(posedge clk);
    e = '0;
    if (!rst_n) begin
      model_zero();
      m_valid = 1;
    end else begin
      e.ovf = m_or | m_of;
      if (m_state == 1)      begin e.seg = font(m_snap / 16); e.dp = 1'b1; end
      else if (m_state == 2) e.seg = font(m_snap % 16);
      else                   e.seg = (m_or | m_of) ? 7'h40 : 7'h00;
      if (clr) begin
        model_zero();
      end else begin
        if (rise_evt) begin
          if (m_rise == 255) m_or = 1; else m_rise++;
        end
        if (fall_evt) begin
          if (m_fall == 255) m_of = 1; else m_fall++;
        end
        per = (m_state == 0) ? BPER : DPER;
        if (m_timer == per - 1) begin
          m_timer = 0;
          if (m_state == 0) begin
            m_state = 1;
            m_snap  = sel ? m_fall : m_rise;
          end else if (m_state == 1) m_state = 2;
          else m_state = 0;
        end else begin
          m_timer++;
        end
      end
    end
    if (m_valid) sb_q.push_back(e);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests_run++;
      if ({seg, dp, ovf} !== e) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t got seg=%h dp=%b ovf=%b want seg=%h dp=%b ovf=%b",
                 $time, seg, dp, ovf, e.seg, e.dp, e.ovf);
      end
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Advance to the first cycle of the next high-digit display, bounded.
  task automatic wait_next_hi();
    int n = 0;
    while (dp !== 1'b0 && n < 40) begin tick(); n++; end
    while (dp !== 1'b1 && n < 40) begin tick(); n++; end
    tests_run++;
    if (dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_hi_timeout dp=%b want 1 within 40 cycles", dp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [6:0] es;
    logic       ed;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (seg !== 7'h00 || dp !== 1'b0 || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold seg=%h dp=%b ovf=%b want 00 0 0", seg, dp, ovf);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      restart_seq(k, es, ed);
      tests_run++;
      if (seg !== es || dp !== ed || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_seq k=%0d seg=%h dp=%b ovf=%b want %h %b 0", k, seg, dp, ovf, es, ed);
      end
    end
  endtask

  task automatic test_count_rise();
    do_clr();
    sel = 1'b0;
    for (int i = 0; i < 26; i++) begin
      rise_evt = 1'b1;
      tick();
    end
    rise_evt = 1'b0;
    wait_next_hi();
    tests_run++;
    if (seg !== 7'h06 || dp !== 1'b1) begin
      tests_failed++;
      $display("FAIL rise26_hi seg=%h dp=%b want 06 1", seg, dp);
    end
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h77 || dp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rise26_lo seg=%h dp=%b want 77 0", seg, dp);
    end
    sel = 1'b1;
    wait_next_hi();
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h3F || dp !== 1'b0) begin
      tests_failed++;
      $display("FAIL fall0_lo seg=%h dp=%b want 3F 0", seg, dp);
    end
  endtask

  task automatic test_simultaneous();
    do_clr();
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rise_evt = 1'b1;
      fall_evt = 1'b1;
      tick();
    end
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      wait_next_hi();
      tests_run++;
      if (seg !== 7'h3F) begin
        tests_failed++;
        $display("FAIL both5_hi pass=%0d seg=%h want 3F", pass, seg);
      end
      ticks(DPER);
      tests_run++;
      if (seg !== 7'h6D) begin
        tests_failed++;
        $display("FAIL both5_lo pass=%0d seg=%h want 6D", pass, seg);
      end
      sel = 1'b0;
    end
  endtask

  task automatic test_saturate();
    do_clr();
    sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rise_evt = 1'b1;
      tick();
    end
    rise_evt = 1'b0;
    ticks(2);
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_ovf ovf=%b want 1", ovf);
    end
    wait_next_hi();
    tests_run++;
    if (seg !== 7'h71) begin
      tests_failed++;
      $display("FAIL sat_hi seg=%h want 71", seg);
    end
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h71) begin
      tests_failed++;
      $display("FAIL sat_lo seg=%h want 71", seg);
    end
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h40 || dp !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_blank seg=%h dp=%b want 40 0", seg, dp);
    end
  endtask

  task automatic test_clr_priority();
    logic [6:0] es;
    logic       ed;
    do_clr();
    sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fall_evt = 1'b1;
      rise_evt = (i < 18);
      tick();
    end
    fall_evt = 1'b0;
    rise_evt = 1'b0;
    ticks(2);
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_pre_ovf ovf=%b want 1", ovf);
    end
    clr      = 1'b1;
    rise_evt = 1'b1;
    tick();
    clr      = 1'b0;
    rise_evt = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      restart_seq(k - 1, es, ed);
      tests_run++;
      if (seg !== es || dp !== ed || ovf !== 1'b0) begin
        tests_failed++;
        $display("FAIL clr_seq k=%0d seg=%h dp=%b ovf=%b want %h %b 0", k, seg, dp, ovf, es, ed);
      end
    end
  endtask

  task automatic test_sel_toggle_reset();
    do_clr();
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rise_evt = 1'b1;
      fall_evt = (i < 3);
      tick();
    end
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    wait_next_hi();
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h77) begin
      tests_failed++;
      $display("FAIL toggle_lo_before seg=%h want 77", seg);
    end
    sel = 1'b1;
    tick();
    tests_run++;
    if (seg !== 7'h77) begin
      tests_failed++;
      $display("FAIL toggle_lo_after seg=%h want 77", seg);
    end
    wait_next_hi();
    tests_run++;
    if (seg !== 7'h3F) begin
      tests_failed++;
      $display("FAIL toggle_next_hi seg=%h want 3F", seg);
    end
    ticks(DPER);
    tests_run++;
    if (seg !== 7'h4F) begin
      tests_failed++;
      $display("FAIL toggle_next_lo seg=%h want 4F", seg);
    end
    wait_next_hi();
    tick();
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (seg !== 7'h00 || dp !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_hi_reset seg=%h dp=%b want 00 0", seg, dp);
    end
    rst_n = 1'b1;
    ticks(3);
  endtask

  initial begin
    rst_n    = 1'b0;
    rise_evt = 1'b0;
    fall_evt = 1'b0;
    sel      = 1'b0;
    clr      = 1'b0;
    m_valid  = 0;
    model_zero();
    test_reset();
    test_count_rise();
    test_simultaneous();
    test_saturate();
    test_clr_priority();
    test_sel_toggle_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
